// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator: opcodes, FSM states and
// the width of the iteration counter used by the multiply/divide unit.
package calc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Enough bits to count from 0 up to and including n iterations.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Shared iterative datapath: shift-add multiply and restoring divide.
// The first iteration is performed on the load edge itself, so after
// 'go' the unit needs N-1 more edges and then raises 'fin' while the
// final product / quotient+remainder sit in hi/lo.
module seq_muldiv
    import calc_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic         is_div,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi,
    output logic         fin
);

    localparam int CW = cnt_width(N);

    logic [N-1:0]  acc;
    logic [N-1:0]  q;
    logic [N-1:0]  m;
    logic [CW-1:0] cnt;
    logic          running;
    logic          div_r;

    logic [N-1:0]  cur_acc;
    logic [N-1:0]  cur_q;
    logic [N-1:0]  cur_m;
    logic          div_mode;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic [N:0]    sum;
    logic [N-1:0]  nxt_acc;
    logic [N-1:0]  nxt_q;

    assign lo  = q;
    assign hi  = acc;
    assign fin = running && (cnt == CW'(N));

    // One multiply or divide iteration, fed from the operands on the load edge.
    always_comb begin
        cur_acc  = go ? '0 : acc;
        cur_q    = go ? a : q;
        cur_m    = go ? b : m;
        div_mode = go ? is_div : div_r;
        shifted  = {cur_acc, cur_q[N-1]};
        trial    = shifted - {1'b0, cur_m};
        sum      = {1'b0, cur_acc} + (cur_q[0] ? {1'b0, cur_m} : '0);
        if (div_mode) begin
            nxt_acc = trial[N] ? shifted[N-1:0] : trial[N-1:0];
            nxt_q   = {cur_q[N-2:0], ~trial[N]};
        end else begin
            nxt_acc = sum[N:1];
            nxt_q   = {sum[0], cur_q[N-1:1]};
        end
    end

    // Accumulator, shift register and step counter; hold once all N steps are done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            cnt     <= '0;
            running <= 1'b0;
            div_r   <= 1'b0;
        end else if (go) begin
            acc     <= nxt_acc;
            q       <= nxt_q;
            m       <= b;
            div_r   <= is_div;
            cnt     <= CW'(1);
            running <= 1'b1;
        end else if (running) begin
            if (fin) begin
                running <= 1'b0;
            end else begin
                acc <= nxt_acc;
                q   <= nxt_q;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_calc_alu.sv
// Clocked calculator with a start/done handshake. Simple ops finish in
// one cycle; MUL and DIV/MOD with a nonzero divisor run through the
// shared iterative unit. Results and flags are held until the next
// accepted operation completes.
module seq_calc_alu
    import calc_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         busy,
    output logic         done,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v,
    output logic         error_div,
    output logic         error_mod
);

    state_e       state;
    state_e       state_nxt;
    op_e          op_in;
    op_e          op_r;
    logic         accept;
    logic         is_iter;
    logic         go;
    logic         load;
    logic         md_fin;
    logic [N-1:0] md_lo;
    logic [N-1:0] md_hi;
    logic [N:0]   wide;
    logic [N-1:0] nxt_lo;
    logic [N-1:0] nxt_hi;
    logic         nxt_c;
    logic         nxt_v;
    logic         nxt_ediv;
    logic         nxt_emod;

    assign op_in = op_e'(op);

    seq_muldiv #(.N(N)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .is_div (op_in != OP_MUL),
        .a      (a),
        .b      (b),
        .lo     (md_lo),
        .hi     (md_hi),
        .fin    (md_fin)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a start in IDLE or DONE is taken, CALC waits for the iterative unit.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nxt = is_iter ? S_CALC : S_DONE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (md_fin) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs and the strobes that start the iterative unit or load results.
    always_comb begin
        is_iter = (op_in == OP_MUL) ||
                  (((op_in == OP_DIV) || (op_in == OP_MOD)) && (b != '0));
        accept  = start && (state != S_CALC);
        busy    = (state == S_CALC);
        done    = (state == S_DONE);
        go      = accept && is_iter;
        load    = (accept && !is_iter) || ((state == S_CALC) && md_fin);
    end

    // Candidate result: iterative unit while calculating, otherwise the single-cycle ALU.
    always_comb begin
        wide     = '0;
        nxt_lo   = '0;
        nxt_hi   = '0;
        nxt_c    = 1'b0;
        nxt_v    = 1'b0;
        nxt_ediv = 1'b0;
        nxt_emod = 1'b0;
        if (state == S_CALC) begin
            case (op_r)
                OP_MUL: begin
                    nxt_lo = md_lo;
                    nxt_hi = md_hi;
                    nxt_c  = (md_hi != '0);
                end
                OP_DIV: begin
                    nxt_lo = md_lo;
                    nxt_hi = md_hi;
                end
                OP_MOD: begin
                    nxt_lo = md_hi;
                    nxt_hi = md_lo;
                end
                default: ;
            endcase
        end else begin
            case (op_in)
                OP_ADD: begin
                    wide   = {1'b0, a} + {1'b0, b};
                    nxt_lo = wide[N-1:0];
                    nxt_c  = wide[N];
                    nxt_v  = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
                end
                OP_SUB: begin
                    wide   = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
                    nxt_lo = wide[N-1:0];
                    nxt_c  = wide[N];
                    nxt_v  = (a[N-1] != b[N-1]) && (wide[N-1] != a[N-1]);
                end
                OP_AND: nxt_lo = a & b;
                OP_OR:  nxt_lo = a | b;
                OP_XOR: nxt_lo = a ^ b;
                OP_SHL: nxt_lo = (32'(b) >= 32'(N)) ? '0 : (a << b);
                OP_SHR: nxt_lo = (32'(b) >= 32'(N)) ? '0 : (a >> b);
                OP_DIV: begin
                    nxt_lo   = '1;
                    nxt_hi   = a;
                    nxt_ediv = 1'b1;
                end
                OP_MOD: begin
                    nxt_lo   = a;
                    nxt_hi   = '1;
                    nxt_emod = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Latched opcode and the registered result/flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= OP_ADD;
            result    <= '0;
            result_hi <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            error_div <= 1'b0;
            error_mod <= 1'b0;
        end else begin
            if (accept) begin
                op_r <= op_in;
            end
            if (load) begin
                result    <= nxt_lo;
                result_hi <= nxt_hi;
                flag_z    <= (nxt_lo == '0);
                flag_n    <= nxt_lo[N-1];
                flag_c    <= nxt_c;
                flag_v    <= nxt_v;
                error_div <= nxt_ediv;
                error_mod <= nxt_emod;
            end
        end
    end

endmodule
